// File: rtl/ps2_tx_apb.sv
// PS/2 host-to-device transmitter with an APB register front end.
// Software pushes command bytes into a small FIFO. The FSM inhibits the bus,
// issues request-to-send, and shifts each byte out on the device's clock. It
// then samples the device ACK. Both pad outputs are open-drain enables.
module ps2_tx_apb #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [2:0]  in_pprot,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned CntMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                       : INHIBIT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    // ------------------------------------------------------------------
    // Pad synchronizers and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_dly_q;
    logic       clk_s;
    logic       data_s;
    logic       clk_fall;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_dly_q & ~clk_s;

    // Two-stage synchronizers; idle level of both lines is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_dly_q   <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_dly_q   <= clk_s;
        end
    end

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       access;
    logic       wr;
    logic       rd;
    logic [1:0] reg_sel;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       busy;
    logic [31:0] status;
    logic [3:0]  count_field;
    logic        unused_bits;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_q, timeout_d;

    assign unused_bits = ^{in_pprot, in_paddr[31:4], in_paddr[1:0], in_pwdata[31:8],
                           in_pstrb[3:1]};

    assign access   = in_psel & in_penable;
    assign wr       = access & in_pwrite;
    assign rd       = access & ~in_pwrite;
    assign reg_sel  = in_paddr[3:2];
    assign full     = (count_q == CountW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr & (reg_sel == 2'd0) & in_pstrb[0];
    // Full is judged on the pre-cycle count, so a same-cycle pop does not help.
    assign push     = push_req & ~full;
    assign busy     = (state_q != StIdle);

    assign count_field = 4'(count_q);

    // STATUS word assembly.
    always_comb begin
        status        = '0;
        status[0]     = busy;
        status[1]     = full;
        status[2]     = empty;
        status[3]     = ack_err_q;
        status[4]     = timeout_q;
        status[11:8]  = count_field;
    end

    assign in_pready   = access;
    assign in_pslverr  = push_req & full;
    assign in_prdata   = (rd && reg_sel == 2'd1) ? status : 32'd0;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // Next pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_pwdata[7:0];
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    // Next-state and registered pad-drive logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;
        pop       = 1'b0;

        if (wr && reg_sel == 2'd1) begin
            if (in_pwdata[3]) ack_err_d = 1'b0;
            if (in_pwdata[4]) timeout_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    parity_d  = ~^mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;  // start bit while the clock is still held
                    state_d   = StRts;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRts: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = StSend;
            end
            StSend: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;  // stop bit: release the line
                        state_d   = StAck;
                    end
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAck: begin
                if (clk_fall) begin
                    if (data_s) ack_err_d = 1'b1;
                    state_d = StWaitIdle;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitIdle: begin
                if (clk_s && data_s) state_d = StIdle;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    // State register; reset releases both lines and flushes the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
